// File: rtl/ec_mem_ctrl_if.sv
// Data-memory bus between the EC-stage controller (master) and the SRAM-like data port (slave).
// Two-phase bus: the request is accepted on addr_ok and the response is returned on data_ok.
interface ec_mem_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/ec_mem_ctrl.sv
// EC-stage data-memory controller: one bus request per load/store, holds the pipeline until data_ok.
// A refresh drains any in-flight response. The optional stall counter is enabled by EC_MEM_PERF_EN.
module ec_mem_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              refresh,
    input  logic              ext_stall,
    input  logic              ec_valid,
    input  logic              ec_load,
    input  logic              ec_store,
    input  logic              ec_except,
    input  logic [31:0]       ec_addr,
    input  logic [3:0]        ec_lsV,
    input  logic [31:0]       ec_wdata,
    ec_mem_ctrl_if.master     bus,
    output logic              mem_stall,
    output logic              ec_data_ok,
    output logic [31:0]       ec_data_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_op;
    logic        access;

    assign mem_op = ec_valid & (ec_load | ec_store);
    assign access = mem_op & ~ec_except & ~refresh;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (access) state_d = bus.data_addr_ok ? S_WAIT : S_REQ;
            end
            S_REQ: begin
                if (bus.data_addr_ok) state_d = refresh ? S_DRAIN : S_WAIT;
                else if (refresh)     state_d = S_IDLE;
            end
            S_WAIT: begin
                // A response that coincides with a flush belongs to the flushed instruction.
                if (refresh) begin
                    state_d = bus.data_data_ok ? S_IDLE : S_DRAIN;
                end else if (bus.data_data_ok) begin
                    state_d = S_DONE;
                    rdata_d = bus.data_rdata;
                end
            end
            S_DONE: begin
                if (refresh || !ext_stall) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.data_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        bus.data_size = 2'd2;
        case (ec_lsV)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: bus.data_size = 2'd0;
            4'b0011, 4'b1100:                   bus.data_size = 2'd1;
            default:                            bus.data_size = 2'd2;
        endcase
    end

    assign bus.data_req   = ((state_q == S_IDLE) & access) | (state_q == S_REQ);
    assign bus.data_wr    = ec_store;
    assign bus.data_addr  = ec_addr;
    assign bus.data_wstrb = ec_store ? ec_lsV : 4'b0000;
    assign bus.data_wdata = ec_wdata;

    assign mem_stall = ((state_q == S_IDLE) & access)
                     | (state_q == S_REQ)
                     | (state_q == S_WAIT)
                     | ((state_q == S_DRAIN) & mem_op);

    assign ec_data_ok    = (state_q == S_DONE);
    assign ec_data_rdata = rdata_q;

`ifdef EC_MEM_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (mem_stall) stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!resetn) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ec_mem_ctrl.sv
// Directed bench for ec_mem_ctrl: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_ec_mem_ctrl;
    localparam int CNT_W = 4;

    logic clk, resetn, refresh, ext_stall;
    logic ec_valid, ec_load, ec_store, ec_except;
    logic [31:0] ec_addr, ec_wdata;
    logic [3:0]  ec_lsV;
    logic        mem_stall, ec_data_ok;
    logic [31:0] ec_data_rdata;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    ec_mem_ctrl_if bus ();

    ec_mem_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .refresh       (refresh),
        .ext_stall     (ext_stall),
        .ec_valid      (ec_valid),
        .ec_load       (ec_load),
        .ec_store      (ec_store),
        .ec_except     (ec_except),
        .ec_addr       (ec_addr),
        .ec_lsV        (ec_lsV),
        .ec_wdata      (ec_wdata),
        .bus           (bus.master),
        .mem_stall     (mem_stall),
        .ec_data_ok    (ec_data_ok),
        .ec_data_rdata (ec_data_rdata),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld, ld, st, exc, rfs, xst, aok, dok;
        logic [31:0] rd;
        logic        e_req, e_stall, e_dok;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vld, ld, st, exc, rfs, xst, aok, dok, input logic [31:0] rd);
        ec_valid = vld; ec_load = ld; ec_store = st; ec_except = exc;
        refresh = rfs; ext_stall = xst;
        bus.data_addr_ok = aok; bus.data_data_ok = dok; bus.data_rdata = rd;
    endtask

    task automatic add(input logic vld, ld, st, exc, rfs, xst, aok, dok, input logic [31:0] rd,
                       input logic e_req, e_stall, e_dok, input logic [31:0] e_rd);
        vec_t v;
        v.vld = vld; v.ld = ld; v.st = st; v.exc = exc; v.rfs = rfs; v.xst = xst;
        v.aok = aok; v.dok = dok; v.rd = rd;
        v.e_req = e_req; v.e_stall = e_stall; v.e_dok = e_dok; v.e_rd = e_rd;
        tbl.push_back(v);
    endtask

    // Drive at posedge+1, sample combinational outputs at posedge+3.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {31'd0, bus.data_req}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall},    32'd0);
        chk("rst_dok",   {31'd0, ec_data_ok},   32'd0);
        chk("rst_rdata", ec_data_rdata,         32'd0);
        chk("rst_cnt",   {28'd0, stall_cnt},    32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        ec_addr = 32'h100; ec_lsV = 4'b1111; ec_wdata = 32'h0;
        do_reset();

        //    vld ld st ex rf xs ao do rdata          req stl dok exp_rdata
        // load word, addr_ok cycle 0, data_ok cycle 2
        add(1, 1, 0, 0, 0, 0, 1, 0, 32'h0,            1, 1, 0, 32'h0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,            0, 1, 0, 32'h0);
        add(1, 1, 0, 0, 0, 0, 0, 1, 32'h12345678,     0, 1, 0, 32'h0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 1, 32'h12345678);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 32'h12345678);
        // refresh in WAIT, response two cycles later is drained
        add(1, 1, 0, 0, 0, 0, 1, 0, 32'h0,            1, 1, 0, 32'h12345678);
        add(1, 1, 0, 0, 1, 0, 0, 0, 32'h0,            0, 1, 0, 32'h12345678);
        add(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,            0, 1, 0, 32'h12345678);
        add(1, 1, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,     0, 1, 0, 32'h12345678);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 32'h12345678);
        // refresh in REQ without addr_ok withdraws the request
        add(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,            1, 1, 0, 32'h12345678);
        add(1, 1, 0, 0, 1, 0, 0, 0, 32'h0,            1, 1, 0, 32'h12345678);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 32'h12345678);
        // exception or refresh in IDLE suppresses the access
        add(1, 1, 0, 1, 0, 0, 0, 0, 32'h0,            0, 0, 0, 32'h12345678);
        add(1, 1, 0, 0, 1, 0, 0, 0, 32'h0,            0, 0, 0, 32'h12345678);
        // refresh together with data_ok in WAIT: back to IDLE, no capture
        add(1, 1, 0, 0, 0, 0, 1, 0, 32'h0,            1, 1, 0, 32'h12345678);
        add(1, 1, 0, 0, 1, 0, 0, 1, 32'hAAAA5555,     0, 1, 0, 32'h12345678);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 32'h12345678);
        // refresh with addr_ok in REQ -> DRAIN, no new request while draining
        add(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,            1, 1, 0, 32'h12345678);
        add(1, 1, 0, 0, 1, 0, 1, 0, 32'h0,            1, 1, 0, 32'h12345678);
        add(1, 1, 0, 0, 0, 0, 1, 0, 32'h0,            0, 1, 0, 32'h12345678);
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h55AA55AA,     0, 0, 0, 32'h12345678);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 32'h12345678);

        for (int i = 0; i < tbl.size(); i++) begin
            next_cycle();
            drive(tbl[i].vld, tbl[i].ld, tbl[i].st, tbl[i].exc, tbl[i].rfs,
                  tbl[i].xst, tbl[i].aok, tbl[i].dok, tbl[i].rd);
            #2;
            chk($sformatf("v%0d_req", i),   {31'd0, bus.data_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("v%0d_stall", i), {31'd0, mem_stall},    {31'd0, tbl[i].e_stall});
            chk($sformatf("v%0d_dok", i),   {31'd0, ec_data_ok},   {31'd0, tbl[i].e_dok});
            chk($sformatf("v%0d_rdata", i), ec_data_rdata,         tbl[i].e_rd);
            if (i == 0) begin
                chk("load_size",  {30'd0, bus.data_size},  32'd2);
                chk("load_wstrb", {28'd0, bus.data_wstrb}, 32'd0);
                chk("load_wr",    {31'd0, bus.data_wr},    32'd0);
                chk("load_addr",  bus.data_addr,           32'h100);
            end
        end

        // store half, addr_ok held low 3 cycles: request visible for 4 cycles
        ec_addr = 32'h200; ec_lsV = 4'b0011; ec_wdata = 32'h0000BEEF;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            drive(1, 0, 1, 0, 0, 0, (c == 3), 0, 32'h0);
            #2;
            chk($sformatf("st_req%0d", c),   {31'd0, bus.data_req},  32'd1);
            chk($sformatf("st_wstrb%0d", c), {28'd0, bus.data_wstrb}, 32'h3);
            chk($sformatf("st_size%0d", c),  {30'd0, bus.data_size},  32'd1);
            chk($sformatf("st_wr%0d", c),    {31'd0, bus.data_wr},    32'd1);
            chk($sformatf("st_stall%0d", c), {31'd0, mem_stall},      32'd1);
        end
        chk("st_wdata", bus.data_wdata, 32'h0000BEEF);
        next_cycle();
        drive(1, 0, 1, 0, 0, 0, 0, 1, 32'h0BAD0BAD);
        #2;
        chk("st_wait_req", {31'd0, bus.data_req}, 32'd0);
        next_cycle();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("st_done_dok",   {31'd0, ec_data_ok}, 32'd1);
        chk("st_done_stall", {31'd0, mem_stall},  32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("st_idle_dok", {31'd0, ec_data_ok}, 32'd0);

        // DONE held by ext_stall for 4 cycles
        ec_addr = 32'h104; ec_lsV = 4'b1111;
        next_cycle();
        drive(1, 1, 0, 0, 0, 0, 1, 0, 32'h0);
        next_cycle();
        drive(1, 1, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            drive(1, 1, 0, 0, 0, 1, 0, 0, 32'h0);
            #2;
            chk($sformatf("hold_dok%0d", c),   {31'd0, ec_data_ok},   32'd1);
            chk($sformatf("hold_rdata%0d", c), ec_data_rdata,         32'hCAFEF00D);
            chk($sformatf("hold_req%0d", c),   {31'd0, bus.data_req}, 32'd0);
            chk($sformatf("hold_stall%0d", c), {31'd0, mem_stall},    32'd0);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("hold_release_dok", {31'd0, ec_data_ok}, 32'd1);
        next_cycle();
        #2;
        chk("hold_idle_dok",   {31'd0, ec_data_ok}, 32'd0);
        chk("hold_idle_rdata", ec_data_rdata,       32'hCAFEF00D);

        // stall counter: 17 stall cycles from reset (1 IDLE-access + 16 WAIT)
        do_reset();
        next_cycle();
        drive(1, 1, 0, 0, 0, 0, 1, 0, 32'h0);
        for (int c = 1; c <= 16; c++) begin
            next_cycle();
            drive(1, 1, 0, 0, 0, 0, 0, (c == 16), 32'h11111111);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("cnt_done_dok", {31'd0, ec_data_ok}, 32'd1);
`ifdef EC_MEM_PERF_EN
        chk("cnt_wrap", {28'd0, stall_cnt}, 32'd1);
`else
        chk("cnt_off", {28'd0, stall_cnt}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
